// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ALU opcodes, major opcodes, decoded bundle and skid state.
package riscv_pkg;

  localparam logic [3:0] ALU_OPC_AND  = 4'b0111;
  localparam logic [3:0] ALU_OPC_OR   = 4'b0110;
  localparam logic [3:0] ALU_OPC_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OPC_ADD  = 4'b0000;
  localparam logic [3:0] ALU_OPC_SUB  = 4'b1000;
  localparam logic [3:0] ALU_OPC_SLT  = 4'b0010;
  localparam logic [3:0] ALU_OPC_SLTU = 4'b0011;
  localparam logic [3:0] ALU_OPC_SLL  = 4'b0001;
  localparam logic [3:0] ALU_OPC_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OPC_SRA  = 4'b1101;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [3:0]  opc;
    logic        sel_pc;
    logic [31:0] pc;
    logic [31:0] reg1;
    logic [31:0] src2;
    logic [4:0]  rd;
    logic        wen;
    logic        illegal;
  } dec_bundle_t;

  typedef enum logic {
    SKID_EMPTY = 1'b0,
    SKID_FULL  = 1'b1
  } skid_state_t;

endpackage

// File: rtl/id_decode.sv
// Combinational decode of OP / OP-IMM / LUI / AUIPC into ALU operands and opcode.
import riscv_pkg::*;

module id_decode (
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output dec_bundle_t bundle
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic        f7_zero;
  logic        f7_alt;

  assign opcode  = instr[6:0];
  assign rd      = instr[11:7];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign imm_u   = {instr[31:12], 12'h000};
  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);

  always_comb begin
    bundle         = '0;
    bundle.pc      = pc;
    bundle.rd      = rd;
    bundle.opc     = ALU_OPC_ADD;
    bundle.illegal = 1'b1;
    case (opcode)
      OPCODE_OP: begin
        if (f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          bundle.illegal = 1'b0;
          bundle.opc     = {instr[30] && (funct3 == 3'b000 || funct3 == 3'b101), funct3};
          bundle.reg1    = rs1_data;
          bundle.src2    = rs2_data;
        end
      end
      OPCODE_OP_IMM: begin
        // Only shifts constrain funct7; other funct3 use bits 31:25 as immediate.
        if ((funct3 == 3'b001) ? f7_zero :
            (funct3 == 3'b101) ? (f7_zero || f7_alt) : 1'b1) begin
          bundle.illegal = 1'b0;
          bundle.opc     = {instr[30] && (funct3 == 3'b101), funct3};
          bundle.reg1    = rs1_data;
          bundle.src2    = imm_i;
        end
      end
      OPCODE_LUI: begin
        bundle.illegal = 1'b0;
        bundle.src2    = imm_u;
      end
      OPCODE_AUIPC: begin
        bundle.illegal = 1'b0;
        bundle.sel_pc  = 1'b1;
        bundle.reg1    = rs1_data;
        bundle.src2    = imm_u;
      end
      default: ;
    endcase
    bundle.wen = !bundle.illegal && (rd != 5'd0);
  end

endmodule

// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register with a one-entry skid buffer so dec_ready is registered.
import riscv_pkg::*;

module id_exe_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid,
  input  logic [31:0] dec_instr,
  input  logic [31:0] dec_pc,
  input  logic [31:0] dec_rs1_data,
  input  logic [31:0] dec_rs2_data,
  output logic        dec_ready,
  input  logic        exe_stall,
  input  logic        exe_flush,
  output logic        exe_valid_r,
  output logic [3:0]  exe_alu_opc_r,
  output logic        exe_sel_pc_r,
  output logic [31:0] exe_pc_r,
  output logic [31:0] exe_reg1_r,
  output logic [31:0] exe_src2_r,
  output logic [4:0]  exe_rd_r,
  output logic        exe_wen_r,
  output logic        exe_illegal_r
);

  dec_bundle_t dec;
  dec_bundle_t skid;
  dec_bundle_t exe;
  skid_state_t state;
  skid_state_t state_next;
  logic        accept;
  logic        load;

  id_decode u_decode (
    .instr    (dec_instr),
    .pc       (dec_pc),
    .rs1_data (dec_rs1_data),
    .rs2_data (dec_rs2_data),
    .bundle   (dec)
  );

  assign dec_ready = (state == SKID_EMPTY);
  assign accept    = dec_valid && dec_ready;
  assign load      = !exe_valid_r || !exe_stall;

  always_ff @(posedge clk) begin
    if (reset) state <= SKID_EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (exe_flush)                          state_next = SKID_EMPTY;
    else if (state == SKID_FULL && load)    state_next = SKID_EMPTY;
    else if (state == SKID_EMPTY && !load && accept) state_next = SKID_FULL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exe_valid_r <= 1'b0;
      exe         <= '0;
      skid        <= '0;
    end else if (exe_flush) begin
      exe_valid_r <= 1'b0;
    end else if (load) begin
      if (state == SKID_FULL) begin
        exe_valid_r <= 1'b1;
        exe         <= skid;
      end else begin
        exe_valid_r <= accept;
        if (accept) exe <= dec;
      end
    end else if (accept) begin
      skid <= dec;
    end
  end

  assign exe_alu_opc_r = exe.opc;
  assign exe_sel_pc_r  = exe.sel_pc;
  assign exe_pc_r      = exe.pc;
  assign exe_reg1_r    = exe.reg1;
  assign exe_src2_r    = exe.src2;
  assign exe_rd_r      = exe.rd;
  assign exe_wen_r     = exe.wen;
  assign exe_illegal_r = exe.illegal;

endmodule

// File: tb/tb_id_exe_stage.sv
// Scoreboard bench for id_exe_stage: directed test-plan cases then random traffic with stalls/flushes.
module tb_id_exe_stage;

  typedef struct packed {
    logic [3:0]  opc;
    logic        sel_pc;
    logic [31:0] pc;
    logic [31:0] reg1;
    logic [31:0] src2;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dec_valid = 1'b0;
  logic [31:0] dec_instr = '0;
  logic [31:0] dec_pc = '0;
  logic [31:0] dec_rs1_data = '0;
  logic [31:0] dec_rs2_data = '0;
  logic        dec_ready;
  logic        exe_stall = 1'b0;
  logic        exe_flush = 1'b0;
  logic        exe_valid_r;
  logic [3:0]  exe_alu_opc_r;
  logic        exe_sel_pc_r;
  logic [31:0] exe_pc_r;
  logic [31:0] exe_reg1_r;
  logic [31:0] exe_src2_r;
  logic [4:0]  exe_rd_r;
  logic        exe_wen_r;
  logic        exe_illegal_r;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  id_exe_stage dut (
    .clk           (clk),
    .reset         (reset),
    .dec_valid     (dec_valid),
    .dec_instr     (dec_instr),
    .dec_pc        (dec_pc),
    .dec_rs1_data  (dec_rs1_data),
    .dec_rs2_data  (dec_rs2_data),
    .dec_ready     (dec_ready),
    .exe_stall     (exe_stall),
    .exe_flush     (exe_flush),
    .exe_valid_r   (exe_valid_r),
    .exe_alu_opc_r (exe_alu_opc_r),
    .exe_sel_pc_r  (exe_sel_pc_r),
    .exe_pc_r      (exe_pc_r),
    .exe_reg1_r    (exe_reg1_r),
    .exe_src2_r    (exe_src2_r),
    .exe_rd_r      (exe_rd_r),
    .exe_wen_r     (exe_wen_r),
    .exe_illegal_r (exe_illegal_r)
  );

  always #5 clk = ~clk;

  // Reference: instruction semantics written from the ISA rules.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit legal;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    e = '0; e.pc = pc; e.rd = ins[11:7];
    legal = 0;
    if (op == 7'h33) begin
      legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      if (legal) begin e.opc = {f7 == 7'h20, f3}; e.reg1 = r1; e.src2 = r2; end
    end else if (op == 7'h13) begin
      if (f3 == 3'd1)      legal = (f7 == 7'h00);
      else if (f3 == 3'd5) legal = (f7 == 7'h00 || f7 == 7'h20);
      else                 legal = 1;
      if (legal) begin
        e.opc = {f3 == 3'd5 && f7 == 7'h20, f3};
        e.reg1 = r1;
        e.src2 = 32'(signed'(ins[31:20]));
      end
    end else if (op == 7'h37) begin
      legal = 1; e.src2 = ins & 32'hFFFFF000;
    end else if (op == 7'h17) begin
      legal = 1; e.sel_pc = 1; e.reg1 = r1; e.src2 = ins & 32'hFFFFF000;
    end
    e.ill = !legal;
    e.wen = legal && (e.rd != 0);
    return e;
  endfunction

  function automatic exp_t dut_bundle();
    return {exe_alu_opc_r, exe_sel_pc_r, exe_pc_r, exe_reg1_r, exe_src2_r,
            exe_rd_r, exe_wen_r, exe_illegal_r};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Monitor: an instruction is consumed when valid and not stalled (and not killed by flush).
  always @(negedge clk) begin
    if (!reset && exe_valid_r && !exe_stall && !exe_flush) begin
      exp_t got;
      exp_t want;
      got = dut_bundle();
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got pc=%h opc=%h with nothing expected", got.pc, got.opc);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          n_err++;
          $display("FAIL sb_bundle: got %h expected %h", got, want);
        end
      end
    end
  end

  task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input bit stall, input bit flush);
    @(posedge clk); #1;
    dec_valid = v; dec_instr = ins; dec_pc = pc;
    dec_rs1_data = r1; dec_rs2_data = r2;
    exe_stall = stall; exe_flush = flush;
    @(negedge clk);
    if (flush) sb.delete();
    else if (dec_valid && dec_ready) sb.push_back(model(ins, pc, r1, r2));
  endtask

  task automatic idle(input bit stall);
    cycle(0, 32'h0, 32'h0, 32'h0, 32'h0, stall, 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  f7s [3];
    ins = $urandom;
    f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'($urandom);
    case ($urandom_range(0, 5))
      0: begin ins[6:0] = 7'h33; ins[31:25] = f7s[$urandom_range(0, 2)]; end
      1: ins[6:0] = 7'h13;
      2: ins[6:0] = 7'h37;
      3: ins[6:0] = 7'h17;
      4: ;
      default: begin
        ins[6:0] = 7'h13;
        ins[14:12] = $urandom_range(0, 1) ? 3'd1 : 3'd5;
        ins[31:25] = f7s[$urandom_range(0, 2)];
      end
    endcase
    return ins;
  endfunction

  initial begin
    exp_t e;
    int guard;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 64'(exe_valid_r), 64'd0);
    chk("reset_ready", 64'(dec_ready), 64'd1);
    chk("reset_payload", 64'({exe_alu_opc_r, exe_sel_pc_r, exe_rd_r, exe_wen_r, exe_illegal_r,
                              |exe_pc_r, |exe_reg1_r, |exe_src2_r}), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // add x3,x1,x2
    cycle(1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 0, 0);
    idle(0);
    chk("add_valid", 64'(exe_valid_r), 64'd1);
    chk("add_fields", 64'({exe_alu_opc_r, exe_reg1_r, exe_src2_r[7:0], exe_rd_r, exe_wen_r, exe_sel_pc_r}),
        64'({4'h0, 32'd5, 8'd7, 5'd3, 1'b1, 1'b0}));

    // srai x5,x6,4
    cycle(1, 32'h40435293, 32'h4, 32'hF000_0000, 32'h0, 0, 0);
    idle(0);
    chk("srai_fields", 64'({exe_alu_opc_r, exe_reg1_r, exe_rd_r}), 64'({4'hD, 32'hF000_0000, 5'd5}));
    chk("srai_imm", 64'(exe_src2_r), 64'h404);

    // auipc x1,0x12345
    cycle(1, 32'h12345097, 32'h100, 32'h0, 32'h0, 0, 0);
    idle(0);
    chk("auipc_fields", 64'({exe_alu_opc_r, exe_sel_pc_r, exe_pc_r}), 64'({4'h0, 1'b1, 32'h100}));
    chk("auipc_imm", 64'(exe_src2_r), 64'h1234_5000);

    // illegal funct7 0100000 with funct3 111
    cycle(1, 32'h4020F1B3, 32'h200, 32'h11, 32'h22, 0, 0);
    idle(0);
    chk("illegal", 64'({exe_valid_r, exe_illegal_r, exe_wen_r, exe_alu_opc_r, exe_reg1_r, exe_src2_r[15:0]}),
        64'({1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 16'h0}));

    // add x0,x1,x2
    cycle(1, 32'h00208033, 32'h204, 32'd1, 32'd2, 0, 0);
    idle(0);
    chk("x0_dest", 64'({exe_valid_r, exe_wen_r, exe_illegal_r}), 64'({1'b1, 1'b0, 1'b0}));

    // Stall/skid: A, then B accepted while EXE stalls on A
    cycle(1, 32'h00100093, 32'h300, 32'h0, 32'h0, 0, 0);
    cycle(1, 32'h00200113, 32'h304, 32'h0, 32'h0, 1, 0);
    idle(1);
    chk("skid_ready_low", 64'(dec_ready), 64'd0);
    chk("skid_hold_a", 64'({exe_valid_r, exe_pc_r}), 64'({1'b1, 32'h300}));
    idle(0);
    idle(0);
    chk("skid_b_out", 64'({exe_valid_r, exe_pc_r, dec_ready}), 64'({1'b1, 32'h304, 1'b1}));
    idle(0);

    // Flush with skid full: nothing survives
    cycle(1, 32'h00300193, 32'h400, 32'h0, 32'h0, 0, 0);
    cycle(1, 32'h00400213, 32'h404, 32'h0, 32'h0, 1, 0);
    cycle(1, 32'h00500293, 32'h408, 32'h0, 32'h0, 1, 1);
    idle(0);
    chk("flush_state", 64'({exe_valid_r, dec_ready}), 64'({1'b0, 1'b1}));
    repeat (3) idle(0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) < 8, rand_instr(), $urandom & 32'hFFFF_FFFC,
            $urandom, $urandom, $urandom_range(0, 9) < 3, $urandom_range(0, 49) == 0);
    end

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      idle(0);
      guard++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    e = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_exe_stage.md
# id_exe_stage

Decode/issue stage that drives the EXE-stage ALU inputs of the RV32I core. Decodes OP, OP-IMM, LUI and AUIPC instructions into the ALU opcode, the PC/reg1 select, and the operand values. Registers the result into the ID/EXE pipeline register, with a one-entry skid buffer so that `dec_ready` is a registered signal. Sits between register-file read and the ALU.

## Interface
- No parameters. XLEN is fixed at 32.
- `clk` in 1: core clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `dec_valid` in 1: instruction offered at decode.
- `dec_instr` in 32: instruction word.
- `dec_pc` in 32: PC of `dec_instr`.
- `dec_rs1_data` in 32: register-file read for rs1.
- `dec_rs2_data` in 32: register-file read for rs2.
- `dec_ready` out 1: registered; stage accepts the instruction this cycle.
- `exe_stall` in 1: EXE cannot consume `exe_*_r` this cycle.
- `exe_flush` in 1: kill all in-flight state in this stage.
- `exe_valid_r` out 1: EXE register holds a valid instruction.
- `exe_alu_opc_r` out 4: ALU opcode.
- `exe_sel_pc_r` out 1: 1 = ALU add uses `exe_pc_r`; 0 = uses `exe_reg1_r`.
- `exe_pc_r` out 32: instruction PC.
- `exe_reg1_r` out 32: first operand.
- `exe_src2_r` out 32: second operand (register value or immediate).
- `exe_rd_r` out 5: destination register.
- `exe_wen_r` out 1: write rd; 0 when rd = x0 or when the instruction is illegal.
- `exe_illegal_r` out 1: unsupported or malformed encoding.

## Operation
- **Accept condition:** `dec_valid && dec_ready`.
- **Decode** (combinational, before any storage):
  - **ALU opcode:** `{b30_qualified, funct3}`.
    - OP: b30 qualifies for funct3 000 and 101.
    - OP-IMM: b30 qualifies for funct3 101 only.
  - **OP:** reg1 = rs1 data, src2 = rs2 data. funct7 must be 0000000, or 0100000 only with funct3 000 or 101.
  - **OP-IMM:** src2 = sign-extended I-immediate. SLLI requires funct7 = 0. SRLI/SRAI require funct7 0000000 or 0100000.
  - **LUI:** opc ADD, sel_pc 0, reg1 forced to 0, src2 = U-immediate.
  - **AUIPC:** opc ADD, sel_pc 1, src2 = U-immediate.
  - **Illegal encoding** (any other opcode or bad funct7): opc ADD, reg1 = src2 = 0, wen 0, illegal 1. The instruction still flows down the pipeline as valid.
- **Skid state:** EMPTY / FULL. `dec_ready` = (state == EMPTY).
- **Output load enable:** `load = !exe_valid_r || !exe_stall`.
- **Per-cycle priority:** reset > `exe_flush` > normal operation.
  - **Flush:** `exe_valid_r` <= 0, skid <= EMPTY. An instruction offered in the same cycle is dropped.
  - `load` and FULL: skid contents -> EXE register; skid <= EMPTY.
  - `load` and EMPTY: `exe_valid_r` <= accept. The decoded payload loads only on accept; otherwise the payload holds.
  - `!load` and accept: decoded instruction -> skid; skid <= FULL.
  - `!load` and no accept: hold everything.
- Payload outputs are stable while `exe_valid_r && exe_stall`.

## Timing
- **Reset values:** every `exe_*_r` = 0 (the opcode reset value decodes as ADD); skid EMPTY; `dec_ready` = 1.
- **Latency:** 1 cycle from accept to `exe_valid_r`.
- **Throughput:** 1 instruction per cycle with no stall.
- **Stall onset:** `dec_ready` falls one cycle after the first stalled accept. At most one extra instruction is absorbed by the skid.
- **Stall release:** the skid entry appears on `exe_*_r` one cycle after `exe_stall` drops. `dec_ready` returns to 1 in that same cycle.
- **Reset or flush with skid FULL:** no instruction survives; `dec_ready` = 1 on the next cycle.
- **Ordering:** no duplication, loss, or reordering under any stall pattern.

## Structure
- **Shared package `riscv_pkg`:**
  - `ALU_OPC_*` constants: AND 0111, OR 0110, XOR 0100, ADD 0000, SUB 1000, SLT 0010, SLTU 0011, SLL 0001, SRL 0101, SRA 1101.
  - Opcode constants: OP 0110011, OP_IMM 0010011, LUI 0110111, AUIPC 0010111.
  - A decoded-bundle struct (opc, sel_pc, pc, reg1, src2, rd, wen, illegal).
- **Sub-module `id_decode`:** purely combinational; instruction plus read data -> bundle. The top level holds the skid buffer and the EXE register.

## Test plan
- **ADD:** `0x002081B3` (add x3,x1,x2), rs1 = 5, rs2 = 7, no stall -> next cycle valid = 1, opc 0000, reg1 = 5, src2 = 7, rd = 3, wen = 1, sel_pc = 0.
- **SRAI:** `0x40435293` (srai x5,x6,4), rs1 = `0xF0000000` -> opc 1101, reg1 = `0xF0000000`, src2 = `0x00000404`, rd = 5.
- **AUIPC:** `0x12345097` (auipc x1,0x12345) at pc `0x100` -> opc 0000, sel_pc = 1, pc = `0x100`, src2 = `0x12345000`.
- **Stall/skid:** A then B back-to-back, `exe_stall` = 1 in the cycle B is accepted.
  - Next cycle: `dec_ready` = 0 and outputs hold A.
  - After the stall drops: B appears and `dec_ready` = 1.
  - A and B each appear exactly once, in order.
- **Flush:** assert `exe_flush` with the skid FULL -> next cycle `exe_valid_r` = 0 and `dec_ready` = 1; neither instruction ever appears.
- **Illegal and x0 destination:**
  - `0x4020F1B3` (funct7 0100000, funct3 111) -> valid = 1, illegal = 1, wen = 0, opc 0000.
  - ADD with rd = x0 -> wen = 0, illegal = 0.
